// File: rtl/core_bus_arb_pkg.sv
// core_bus_arb_pkg
//   Shared types and constants for the two-master core bus arbiter.
//   - addr_t        : core address word (AW = 32)
//   - arb_state_t   : arbiter FSM encoding (idle, I granted, D granted)
//   - ARB_MAX_HOLD_DEF : default number of acks the owner may take while
//                        the other master waits before a forced handoff
package core_bus_arb_pkg;

    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_t;

    localparam int ARB_MAX_HOLD_DEF = 8;

endpackage

// File: rtl/core_bus_arb.sv
// core_bus_arb
//   Two-master Wishbone arbiter: instruction fetch (I) and data memory (D)
//   share one memory slave port. D wins simultaneous requests; a bounded
//   hold counter forces a handoff so neither master starves the other.
//
// Ports
//   clk, rst                 : core clock, synchronous active-high reset
//   i_cyc/stb/we/adr/dat_mo  : I master request
//   i_ack, i_dat_so          : I master response (0 unless I is granted)
//   d_cyc/stb/we/adr/dat_mo  : D master request
//   d_ack, d_dat_so          : D master response (0 unless D is granted)
//   s_cyc/stb/we/adr/dat_mo  : request forwarded to the slave
//   s_ack, s_dat_so          : slave response
//   gnt                      : registered one-hot grant {D,I}; also the
//                              externally visible FSM state (00 = idle)
//
// Handshake: a master holds cyc/stb/adr until it sees its ack; the ack
// cycle completes the transfer. One request is outstanding at a time.
module core_bus_arb
    import core_bus_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cyc,
    input  logic          i_stb,
    input  logic          i_we,
    input  logic [AW-1:0] i_adr,
    input  logic [DW-1:0] i_dat_mo,
    output logic          i_ack,
    output logic [DW-1:0] i_dat_so,
    input  logic          d_cyc,
    input  logic          d_stb,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_dat_mo,
    output logic          d_ack,
    output logic [DW-1:0] d_dat_so,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_mo,
    input  logic          s_ack,
    input  logic [DW-1:0] s_dat_so,
    output logic [1:0]    gnt
);

    // A zero-width counter is illegal, so MAX_HOLD=0 keeps one unused bit.
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        gnt_q;
    logic              other_cyc;
    logic              handoff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            hold_q  <= '0;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gnt_q   <= {state_d == ARB_GNT_D, state_d == ARB_GNT_I};
        end
    end

    assign gnt = gnt_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        other_cyc = 1'b0;
        handoff   = 1'b0;
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_adr     = '0;
        s_dat_mo  = '0;
        i_ack     = 1'b0;
        i_dat_so  = '0;
        d_ack     = 1'b0;
        d_dat_so  = '0;

        case (state_q)
            ARB_GNT_I: begin
                other_cyc = d_cyc;
                s_cyc     = i_cyc;
                s_stb     = i_stb;
                s_we      = i_we;
                s_adr     = i_adr;
                s_dat_mo  = i_dat_mo;
                // Gate with cyc so a stray slave ack never reaches an idle master.
                i_ack     = i_cyc & s_ack;
                i_dat_so  = s_dat_so;
            end
            ARB_GNT_D: begin
                other_cyc = i_cyc;
                s_cyc     = d_cyc;
                s_stb     = d_stb;
                s_we      = d_we;
                s_adr     = d_adr;
                s_dat_mo  = d_dat_mo;
                d_ack     = d_cyc & s_ack;
                d_dat_so  = s_dat_so;
            end
            default: ;
        endcase

        // The handoff fires on the owner's last allowed ack; that ack is still
        // delivered to the owner above, so the transfer completes before the
        // grant moves at this edge.
        handoff = (MAX_HOLD != 0) && other_cyc && s_ack && (hold_q == HOLD_LAST);

        case (state_q)
            ARB_IDLE: begin
                if (d_cyc)      state_d = ARB_GNT_D;
                else if (i_cyc) state_d = ARB_GNT_I;
            end
            ARB_GNT_I: begin
                if (!i_cyc)       state_d = d_cyc ? ARB_GNT_D : ARB_IDLE;
                else if (handoff) state_d = ARB_GNT_D;
            end
            ARB_GNT_D: begin
                if (!d_cyc)       state_d = i_cyc ? ARB_GNT_I : ARB_IDLE;
                else if (handoff) state_d = ARB_GNT_I;
            end
            default: state_d = ARB_IDLE;
        endcase

        if ((state_q == ARB_IDLE) || (state_d != state_q)) begin
            hold_d = '0;
        end else if (s_ack && other_cyc && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
        end
    end

endmodule
